// File: rtl/idct_pkg.sv
// Shared types and constants for the 8-point 1-D inverse DCT.
package idct_pkg;

    // Block-level sequencing: gather 8 coefficients, two compute cycles, hold result.
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CALC1   = 2'd1,
        ST_CALC2   = 2'd2,
        ST_OUT     = 2'd3
    } state_t;

    // Accumulator width; wide enough for 8 x 12-bit products with 8-bit constants.
    localparam int ACC_W    = 24;

    // Fixed-point scale of the cosine constants (x256) and its half-LSB rounding term.
    localparam int ROUND_SH = 8;
    localparam logic signed [ACC_W-1:0] ROUND_K = 24'sd128;

    // DC weight: round(256 * 1/(2*sqrt2)).
    localparam logic signed [ACC_W-1:0] C_DC = 24'sd91;

    // AC weights: round(128 * cos(j*pi/16)), j = 1..7.
    localparam logic signed [ACC_W-1:0] C1 = 24'sd126;
    localparam logic signed [ACC_W-1:0] C2 = 24'sd118;
    localparam logic signed [ACC_W-1:0] C3 = 24'sd106;
    localparam logic signed [ACC_W-1:0] C4 = 24'sd91;
    localparam logic signed [ACC_W-1:0] C5 = 24'sd71;
    localparam logic signed [ACC_W-1:0] C6 = 24'sd49;
    localparam logic signed [ACC_W-1:0] C7 = 24'sd25;

endpackage

// File: rtl/idct_butterfly8.sv
// Combinational datapath of the 8-point IDCT: even/odd partial products from
// the coefficient buffer, and the final butterfly with round-and-saturate.
// The two halves are used in consecutive cycles with registers in between
// held by the parent.
module idct_butterfly8
    import idct_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  coef  [8],
    output logic signed [ACC_W-1:0] e_sum [4],
    output logic signed [ACC_W-1:0] o_sum [4],
    input  logic signed [ACC_W-1:0] e_in  [4],
    input  logic signed [ACC_W-1:0] o_in  [4],
    output logic signed [OUT_W-1:0] x_out [8]
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (OUT_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    logic signed [ACC_W-1:0] xk [8];

    genvar gi;

    // Sign-extend each coefficient to accumulator width before multiplying.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ext
            assign xk[gi] = {{(ACC_W - IN_W){coef[gi][IN_W-1]}}, coef[gi]};
        end
    endgenerate

    // Even part from X0/X2/X4/X6 and odd part from X1/X3/X5/X7; signs follow
    // cos((2n+1)k*pi/16) for rows n = 0..3.
    always_comb begin
        e_sum[0] = C_DC * xk[0] + C2 * xk[2] + C4 * xk[4] + C6 * xk[6];
        e_sum[1] = C_DC * xk[0] + C6 * xk[2] - C4 * xk[4] - C2 * xk[6];
        e_sum[2] = C_DC * xk[0] - C6 * xk[2] - C4 * xk[4] + C2 * xk[6];
        e_sum[3] = C_DC * xk[0] - C2 * xk[2] + C4 * xk[4] - C6 * xk[6];

        o_sum[0] = C1 * xk[1] + C3 * xk[3] + C5 * xk[5] + C7 * xk[7];
        o_sum[1] = C3 * xk[1] - C7 * xk[3] - C1 * xk[5] - C5 * xk[7];
        o_sum[2] = C5 * xk[1] - C1 * xk[3] + C7 * xk[5] + C3 * xk[7];
        o_sum[3] = C7 * xk[1] - C5 * xk[3] + C3 * xk[5] - C1 * xk[7];
    end

    // Add half an LSB, floor-shift out the constant scale, clamp to OUT_W.
    function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        r = (a + ROUND_K) >>> ROUND_SH;
        if (r > SAT_MAX) begin
            round_sat = OUT_W'(SAT_MAX);
        end else if (r < SAT_MIN) begin
            round_sat = OUT_W'(SAT_MIN);
        end else begin
            round_sat = OUT_W'(r);
        end
    endfunction

    // Mirror butterfly: x[n] = E[n] + O[n], x[7-n] = E[n] - O[n].
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bfly
            assign x_out[gi]     = round_sat(e_in[gi] + o_in[gi]);
            assign x_out[7 - gi] = round_sat(e_in[gi] - o_in[gi]);
        end
    endgenerate

endmodule

// File: rtl/loeffler_idct_1d.sv
// 8-point 1-D inverse DCT. Coefficients arrive serially X[0]..X[7]; the
// eight reconstructed samples are presented together behind a valid/ready
// output register. Latency from the 8th accepted beat to out_valid is 3.
module loeffler_idct_1d
    import idct_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out0,
    output logic signed [OUT_W-1:0] out1,
    output logic signed [OUT_W-1:0] out2,
    output logic signed [OUT_W-1:0] out3,
    output logic signed [OUT_W-1:0] out4,
    output logic signed [OUT_W-1:0] out5,
    output logic signed [OUT_W-1:0] out6,
    output logic signed [OUT_W-1:0] out7
);

    state_t                  state_q,     state_d;
    logic [2:0]              idx_q,       idx_d;
    logic                    in_ready_q,  in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [IN_W-1:0]  coef_q [8];
    logic signed [IN_W-1:0]  coef_d [8];
    logic signed [ACC_W-1:0] e_q    [4];
    logic signed [ACC_W-1:0] e_d    [4];
    logic signed [ACC_W-1:0] o_q    [4];
    logic signed [ACC_W-1:0] o_d    [4];
    logic signed [OUT_W-1:0] out_q  [8];
    logic signed [OUT_W-1:0] out_d  [8];

    logic signed [ACC_W-1:0] e_w [4];
    logic signed [ACC_W-1:0] o_w [4];
    logic signed [OUT_W-1:0] x_w [8];

    logic beat_acc;
    logic out_acc;

    idct_butterfly8 #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_bfly (
        .coef  (coef_q),
        .e_sum (e_w),
        .o_sum (o_w),
        .e_in  (e_q),
        .o_in  (o_q),
        .x_out (x_w)
    );

    assign beat_acc = in_valid && in_ready_q;
    assign out_acc  = out_valid_q && out_ready;

    // Next-state, buffer write and pipeline-register loads; handshake flags are
    // decoded from the next state so they come straight out of flops.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        coef_d  = coef_q;
        e_d     = e_q;
        o_d     = o_q;
        out_d   = out_q;

        case (state_q)
            ST_COLLECT: begin
                if (beat_acc) begin
                    coef_d[idx_q] = in_data;
                    idx_d         = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_CALC1;
                    end
                end
            end
            ST_CALC1: begin
                e_d     = e_w;
                o_d     = o_w;
                state_d = ST_CALC2;
            end
            ST_CALC2: begin
                out_d   = x_w;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_acc) begin
                    state_d = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase

        in_ready_d  = (state_d == ST_COLLECT);
        out_valid_d = (state_d == ST_OUT);
    end

    // Control and output registers; reset drops any partial or pending block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_COLLECT;
            idx_q       <= 3'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    // Datapath storage needs no reset: it is always written before it is used.
    always_ff @(posedge clk) begin
        coef_q <= coef_d;
        e_q    <= e_d;
        o_q    <= o_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign out2      = out_q[2];
    assign out3      = out_q[3];
    assign out4      = out_q[4];
    assign out5      = out_q[5];
    assign out6      = out_q[6];
    assign out7      = out_q[7];

endmodule

// File: tb/tb_loeffler_idct_1d.sv
// Directed bench for loeffler_idct_1d: a 16-bit instance for the main
// transform and an OUT_W=9 instance, fed the same stream, for clamping.
module tb_loeffler_idct_1d;

    logic clk;
    logic rst;
    logic in_valid;
    logic signed [11:0] in_data;
    logic out_ready;

    logic in_ready, out_valid;
    logic signed [15:0] out0, out1, out2, out3, out4, out5, out6, out7;

    logic s_in_ready, s_out_valid;
    logic signed [8:0] s0, s1, s2, s3, s4, s5, s6, s7;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference matrix M[n][k], row-major, hand-derived from the cosine table.
    int m_tab [64] = '{
          91,  126,  118,  106,   91,   71,   49,   25,
          91,  106,   49,  -25,  -91, -126, -118,  -71,
          91,   71,  -49, -126,  -91,   25,  118,  106,
          91,   25, -118,  -71,   91,  106,  -49, -126,
          91,  -25, -118,   71,   91, -106,  -49,  126,
          91,  -71,  -49,  126,  -91,  -25,  118, -106,
          91, -106,   49,   25,  -91,  126, -118,   71,
          91, -126,  118, -106,   91,  -71,   49,  -25
    };

    loeffler_idct_1d #(.IN_W(12), .OUT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out5(out5), .out6(out6), .out7(out7)
    );

    loeffler_idct_1d #(.IN_W(12), .OUT_W(9)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out0(s0), .out1(s1), .out2(s2), .out3(s3),
        .out4(s4), .out5(s5), .out6(s6), .out7(s7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int lane(input int n);
        case (n)
            0: return int'(out0);
            1: return int'(out1);
            2: return int'(out2);
            3: return int'(out3);
            4: return int'(out4);
            5: return int'(out5);
            6: return int'(out6);
            7: return int'(out7);
            default: return 0;
        endcase
    endfunction

    function automatic int lane_sat(input int n);
        case (n)
            0: return int'(s0);
            1: return int'(s1);
            2: return int'(s2);
            3: return int'(s3);
            4: return int'(s4);
            5: return int'(s5);
            6: return int'(s6);
            7: return int'(s7);
            default: return 0;
        endcase
    endfunction

    // Golden matrix-product model: round, floor-shift, clamp to w bits.
    function automatic int ref_x(input int v[8], input int n, input int w);
        int s;
        int hi;
        int lo;
        s = 0;
        for (int k = 0; k < 8; k++) s += v[k] * m_tab[n * 8 + k];
        s  = (s + 128) >>> 8;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return s;
    endfunction

    // Stream one block; a beat counts when in_ready is high at its edge.
    task automatic send_block(input int v[8]);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < 8 && guard < 100) begin
            in_valid = 1'b1;
            in_data  = 12'(v[i]);
            if (in_ready) i++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 100) check("send_timeout", 0, 1);
    endtask

    // Send a block, wait for out_valid (expect 3 cycles), compare all lanes.
    task automatic collect(input string tag, input int v[8]);
        int lat;
        send_block(v);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        for (int n = 0; n < 8; n++) begin
            check($sformatf("%s_x%0d", tag, n), lane(n), ref_x(v, n, 16));
            check($sformatf("%s_sat_x%0d", tag, n), lane_sat(n), ref_x(v, n, 9));
        end
        $display("blk %-10s lat=%0d x = %0d %0d %0d %0d %0d %0d %0d %0d", tag, lat,
                 lane(0), lane(1), lane(2), lane(3), lane(4), lane(5), lane(6), lane(7));
    endtask

    // One-cycle output handshake; the block must go idle and re-open input.
    task automatic accept(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ovalid_drop"}, out_valid, 0);
        check({tag, "_inrdy_back"}, in_ready, 1);
    endtask

    int dc  [8] = '{256, 0, 0, 0, 0, 0, 0, 0};
    int ac1 [8] = '{0, 256, 0, 0, 0, 0, 0, 0};
    int fs  [8] = '{2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047};
    int sp  [8] = '{1000, 0, 0, 0, 0, 0, 0, 0};
    int sn  [8] = '{-1000, 0, 0, 0, 0, 0, 0, 0};
    int mix [8] = '{-2048, 2047, -2048, 2047, -2048, 2047, -2048, 2047};
    int rnd [8];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        for (int n = 0; n < 8; n++) check($sformatf("rst_x%0d", n), lane(n), 0);

        // DC only: every sample is 91
        collect("dc", dc);
        for (int n = 0; n < 8; n++) check($sformatf("dc_hand_x%0d", n), lane(n), 91);
        accept("dc");

        // Single AC: odd symmetry and floor rounding of negatives
        collect("ac1", ac1);
        check("ac1_hand_x0", lane(0), 126);
        check("ac1_hand_x3", lane(3), 25);
        check("ac1_hand_x4", lane(4), -25);
        check("ac1_hand_x7", lane(7), -126);
        accept("ac1");

        // Full scale on every coefficient
        collect("fullscale", fs);
        check("fs_hand_x0", lane(0), 5413);
        accept("fullscale");

        // Alternating extremes
        collect("mix", mix);
        accept("mix");

        // Clamping in the 9-bit instance
        collect("sat_pos", sp);
        for (int n = 0; n < 8; n++) check($sformatf("satp_hand_x%0d", n), lane_sat(n), 255);
        check("satp_valid", s_out_valid, 1);
        accept("sat_pos");
        collect("sat_neg", sn);
        for (int n = 0; n < 8; n++) check($sformatf("satn_hand_x%0d", n), lane_sat(n), -256);
        check("satn_valid", s_out_valid, 1);
        accept("sat_neg");

        // Backpressure: output held, input stays closed while in_valid is driven
        collect("bp", ac1);
        in_valid = 1'b1;
        in_data  = 12'sd1000;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("bp_hold_x0", lane(0), 126);
            check("bp_hold_x7", lane(7), -126);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        accept("bp");
        collect("bp_next", dc);
        for (int n = 0; n < 8; n++) check($sformatf("bpn_hand_x%0d", n), lane(n), 91);
        accept("bp_next");

        // out_ready held high: out_valid lasts exactly one cycle
        out_ready = 1'b1;
        collect("ordy_hi", fs);
        @(posedge clk); #1;
        check("ordy_hi_pulse", out_valid, 0);
        check("ordy_hi_inrdy", in_ready, 1);
        out_ready = 1'b0;

        // Reset after 5 beats discards the partial block
        in_valid = 1'b1;
        in_data  = 12'sd700;
        repeat (5) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_in_ready", in_ready, 1);
        check("rstmid_out_valid", out_valid, 0);
        collect("rst_dc", dc);
        for (int n = 0; n < 8; n++) check($sformatf("rstdc_hand_x%0d", n), lane(n), 91);

        // Reset while holding a result clears the outputs
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstout_out_valid", out_valid, 0);
        check("rstout_in_ready", in_ready, 1);
        for (int n = 0; n < 8; n++) check($sformatf("rstout_x%0d", n), lane(n), 0);

        // A few pseudo-random blocks against the matrix model
        for (int b = 0; b < 20; b++) begin
            for (int k = 0; k < 8; k++) rnd[k] = int'($urandom_range(4095)) - 2048;
            collect($sformatf("rnd%0d", b), rnd);
            accept($sformatf("rnd%0d", b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
